// File: rtl/cpld_link_pkg.sv
// Shared constants and helpers for the FPGA<->CPLD 4-wire serial frame link.
package cpld_link_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned SEG_MSB    = 15;
  localparam int unsigned SEG_LSB    = 8;
  localparam int unsigned LED_MSB    = 4;
  localparam int unsigned BTN_TX_LSB = 3;
  localparam int unsigned BTN_W      = 5;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [2:0] {
    BTN_SEL   = 3'd0,
    BTN_UP    = 3'd1,
    BTN_DOWN  = 3'd2,
    BTN_RIGHT = 3'd3,
    BTN_LEFT  = 3'd4
  } btn_idx_e;

  // Status word returned to the master: buttons at bits [7:3], all else zero.
  function automatic logic [FRAME_BITS-1:0] tx_word(input logic [BTN_W-1:0] btn);
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[BTN_TX_LSB +: BTN_W] = btn;
    return w;
  endfunction

endpackage

// File: rtl/cpld_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall detection
// on the synchronized value. All flops clear on reset so no edge is seen after it.
module cpld_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/cpld_frame_slave.sv
// CPLD-side frame responder: receives 7-seg/LED frames, returns button status.
// Optional frame watchdog blanking enabled by defining CPLD_FRAME_WDOG_EN.
module cpld_frame_slave
  import cpld_link_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TO_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_load,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [4:0] btn_n,
  output logic [7:0] seg_n,
  output logic       dig_sel,
  output logic [4:0] leds,
  output logic       frame_err
);

  if (SYNC_STAGES < 2 || TO_W < 1) begin : g_param_check
    $error("cpld_frame_slave: SYNC_STAGES must be >= 2 and TO_W >= 1");
  end

  logic w_clk_sync, w_clk_rise, w_clk_fall;
  logic w_load_sync, w_load_rise, w_load_fall;
  logic w_mosi_s, w_mosi_rise, w_mosi_fall;

  cpld_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .i_async(spi_clk),
    .o_sync(w_clk_sync), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
  );

  cpld_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk(clk), .rst(rst), .i_async(spi_load),
    .o_sync(w_load_sync), .o_rise(w_load_rise), .o_fall(w_load_fall)
  );

  cpld_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_async(spi_mosi),
    .o_sync(w_mosi_s), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  logic [BTN_W-1:0] r_btn_meta, r_btn_sync;
  logic [BTN_W-1:0] w_btn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_meta <= '1;
      r_btn_sync <= '1;
    end else begin
      r_btn_meta <= btn_n;
      r_btn_sync <= r_btn_meta;
    end
  end

  assign w_btn = ~r_btn_sync;

  logic [FRAME_BITS-1:0] r_rx_shr, r_tx_shr;
  logic [4:0]            r_bit_cnt;
  logic [7:0]            r_seg_n;
  logic [LED_MSB:0]      r_leds;
  logic                  r_dig_sel, r_frame_err;
  logic                  w_frame_full, w_commit_ok;

  assign w_frame_full = (r_bit_cnt == 5'(FRAME_BITS));
  assign w_commit_ok  = w_load_fall & w_frame_full;

  // load_fall outranks both shift edges; a coincident clk_rise is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_shr  <= '0;
      r_bit_cnt <= '0;
    end else if (w_load_fall) begin
      r_bit_cnt <= '0;
    end else if (w_clk_rise) begin
      r_rx_shr <= {w_mosi_s, r_rx_shr[FRAME_BITS-1:1]};
      if (!w_frame_full) r_bit_cnt <= r_bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shr <= '0;
    end else if (w_load_fall) begin
      r_tx_shr <= tx_word(w_btn);
    end else if (w_clk_fall) begin
      r_tx_shr <= {r_tx_shr[FRAME_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_n     <= SEG_BLANK;
      r_leds      <= '0;
      r_dig_sel   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_load_fall & ~w_frame_full;
      if (w_commit_ok) begin
        r_seg_n   <= r_rx_shr[SEG_MSB:SEG_LSB];
        r_leds    <= r_rx_shr[LED_MSB:0];
        r_dig_sel <= ~r_dig_sel;
      end
    end
  end

  logic w_blank;

`ifdef CPLD_FRAME_WDOG_EN
  logic [TO_W-1:0] r_wdog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '1;
    end else if (w_commit_ok) begin
      r_wdog <= '0;
    end else if (r_wdog != '1) begin
      r_wdog <= r_wdog + TO_W'(1);
    end
  end

  assign w_blank = &r_wdog;
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    seg_n = r_seg_n;
    leds  = r_leds;
    if (w_blank) begin
      seg_n = SEG_BLANK;
      leds  = '0;
    end
  end

  assign dig_sel   = r_dig_sel;
  assign frame_err = r_frame_err;
  assign spi_miso  = r_tx_shr[FRAME_BITS-1];

  logic w_unused;
  assign w_unused = ^{w_clk_sync, w_load_sync, w_load_rise, w_mosi_rise,
                      w_mosi_fall, r_rx_shr[SEG_LSB-1:LED_MSB+1]};

endmodule

// File: tb/tb_cpld_frame_slave.sv
// Directed self-checking bench for cpld_frame_slave (link frames, errors, reset).
module tb_cpld_frame_slave;

  localparam int HALF = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_load = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [4:0] btn_n = 5'b11111;
  logic [7:0] seg_n;
  logic       dig_sel;
  logic [4:0] leds;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;

  cpld_frame_slave #(.SYNC_STAGES(2), .TO_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_clk  (spi_clk),
    .spi_load (spi_load),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .btn_n    (btn_n),
    .seg_n    (seg_n),
    .dig_sel  (dig_sel),
    .leds     (leds),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bit period: data set at the falling edge, miso sampled mid-high and at the next fall.
  task automatic send_bit(input logic b, input logic last, output logic rs, output logic fs);
    spi_mosi = b;
    spi_load = last;
    #HALF;
    spi_clk = 1'b1;
    #(HALF/2);
    rs = spi_miso;
    #(HALF/2);
    fs = spi_miso;
    spi_clk = 1'b0;
    if (last) spi_load = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] w, input int nbits,
                            output logic [15:0] rx_rise, output logic [15:0] rx_fall);
    logic r, f;
    rx_rise = '0;
    rx_fall = '0;
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[i], (i == nbits - 1), r, f);
      rx_rise = {rx_rise[14:0], r};
      rx_fall = {rx_fall[14:0], f};
    end
    #100;
  endtask

  logic [15:0] rr, rf;
  logic        r1, f1;
  int          e0;
  logic [15:0] words [4];

  initial begin
    words[0] = 16'h1101;
    words[1] = 16'h2202;
    words[2] = 16'h3303;
    words[3] = 16'h4404;

    #40 rst = 1'b0;
    #20;
    check("reset_seg",  16'(seg_n), 16'h00FF);
    check("reset_leds", 16'(leds), 16'h0000);
    check("reset_dig",  16'(dig_sel), 16'h0000);
    check("reset_err",  16'(frame_err), 16'h0000);
    check("reset_miso", 16'(spi_miso), 16'h0000);

    btn_n = 5'b11010;
    #40;
    e0 = err_cnt;
    send_frame(16'h6D05, 16, rr, rf);
    check("f1_seg",  16'(seg_n), 16'h006D);
    check("f1_leds", 16'(leds), 16'h0005);
    check("f1_dig",  16'(dig_sel), 16'h0001);
    check("f1_err",  16'(err_cnt - e0), 16'h0000);

    send_frame(16'h3F1F, 16, rr, rf);
    check("f2_miso_fall", rf, 16'h0028);
    check("f2_miso_mid",  rr, 16'h0028);
    check("f2_seg",  16'(seg_n), 16'h003F);
    check("f2_leds", 16'(leds), 16'h001F);
    check("f2_dig",  16'(dig_sel), 16'h0000);

    e0 = err_cnt;
    send_frame(16'hABCD, 12, rr, rf);
    check("short_err",  16'(err_cnt - e0), 16'h0001);
    check("short_seg",  16'(seg_n), 16'h003F);
    check("short_leds", 16'(leds), 16'h001F);
    check("short_dig",  16'(dig_sel), 16'h0000);

    send_frame(16'h0612, 16, rr, rf);
    check("after_short_seg",  16'(seg_n), 16'h0006);
    check("after_short_leds", 16'(leds), 16'h0012);
    check("after_short_dig",  16'(dig_sel), 16'h0001);

    e0 = err_cnt;
    for (int i = 0; i < 16; i++) begin
      if (i == 7) rst = 1'b1;
      if (i == 8) check("rst_during_seg", 16'(seg_n), 16'h00FF);
      if (i == 9) rst = 1'b0;
      send_bit(1'b1, (i == 15), r1, f1);
    end
    #100;
    check("rst_partial_err",  16'(err_cnt - e0), 16'h0001);
    check("rst_partial_seg",  16'(seg_n), 16'h00FF);
    check("rst_partial_leds", 16'(leds), 16'h0000);
    check("rst_partial_dig",  16'(dig_sel), 16'h0000);

    send_frame(16'hF900, 16, rr, rf);
    check("rst_next_seg",  16'(seg_n), 16'h00F9);
    check("rst_next_leds", 16'(leds), 16'h0000);
    check("rst_next_dig",  16'(dig_sel), 16'h0001);

    rst = 1'b1;
    #20 rst = 1'b0;
    btn_n = 5'b01110;
    #40;
    for (int k = 0; k < 4; k++) begin
      send_frame(words[k], 16, rr, rf);
      check($sformatf("seq%0d_dig", k), 16'(dig_sel), (k % 2 == 0) ? 16'h0001 : 16'h0000);
      check($sformatf("seq%0d_seg", k), 16'(seg_n), 16'(words[k][15:8]));
      check($sformatf("seq%0d_miso_fall", k), rf, (k == 0) ? 16'h0000 : 16'h0088);
      check($sformatf("seq%0d_miso_mid", k), rr, (k == 0) ? 16'h0000 : 16'h0088);
    end

`ifdef CPLD_FRAME_WDOG_EN
    #3000;
    check("wdog_seg",  16'(seg_n), 16'h00FF);
    check("wdog_leds", 16'(leds), 16'h0000);
    send_frame(16'h5A1B, 16, rr, rf);
    check("wdog_restore_seg",  16'(seg_n), 16'h005A);
    check("wdog_restore_leds", 16'(leds), 16'h001B);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
